// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink sequencer.
package blink_pkg;

    // Sequencer states: idle, LED lit, LED dark gap after a blink.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    localparam int TIMER_W = 32;
    localparam int COUNT_W = 4;

    // Clock cycles in an interval of 'ms' milliseconds at 'freq_hz'.
    // Dividing first keeps the product inside 32 bits for any sane clock.
    function automatic logic [TIMER_W-1:0] ticks_from_ms(
        input int unsigned freq_hz,
        input int unsigned ms
    );
        int unsigned per_ms;
        per_ms = freq_hz / 1000;
        return TIMER_W'(per_ms * ms);
    endfunction

endpackage

// File: rtl/led_blinker_if.sv
// Request/status bundle between a blink requester and the LED sequencer.
interface led_blinker_if;
    import blink_pkg::*;

    logic               start;
    logic [COUNT_W-1:0] count;
    logic               led;
    logic               busy;
    logic               done;

    // Requester side: issues start/count, watches status.
    modport master (
        output start,
        output count,
        input  led,
        input  busy,
        input  done
    );

    // Sequencer side: consumes requests, drives LED and status.
    modport slave (
        input  start,
        input  count,
        output led,
        output busy,
        output done
    );

endinterface

// File: rtl/interval_timer.sv
// Clearable 32-bit up-counter; expire flags the last cycle of an interval
// of 'limit' cycles, counting from the cycle after a clear.
module interval_timer
    import blink_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [TIMER_W-1:0] limit,
    output logic               expire
);

    logic [TIMER_W-1:0] count_reg;
    logic [TIMER_W-1:0] count_next;

    // Clear wins over counting; the owner clears on every expiry, so the
    // counter never runs past limit-1 and cannot wrap.
    always_comb begin
        count_next = count_reg + TIMER_W'(1);
        if (clr) begin
            count_next = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = (count_reg == (limit - TIMER_W'(1)));

endmodule

// File: rtl/led_blinker.sv
// LED blink sequencer: on a start request, blinks the LED 'count' times
// (on_ms lit, off_ms dark each), pulses done at the end, and can hold one
// queued request that launches back-to-back with the running sequence.
module led_blinker
    import blink_pkg::*;
#(
    parameter int unsigned clk_freq = 50_000_000,
    parameter int unsigned on_ms    = 100,
    parameter int unsigned off_ms   = 100
) (
    input  logic          clk,
    input  logic          rst,
    led_blinker_if.slave  bus
);

    localparam logic [TIMER_W-1:0] ON_TICKS  = ticks_from_ms(clk_freq, on_ms);
    localparam logic [TIMER_W-1:0] OFF_TICKS = ticks_from_ms(clk_freq, off_ms);

    blink_state_t       state_reg;
    blink_state_t       state_next;
    logic [COUNT_W-1:0] remaining_reg;
    logic [COUNT_W-1:0] remaining_next;
    logic               pend_valid_reg;
    logic               pend_valid_next;
    logic [COUNT_W-1:0] pend_count_reg;
    logic [COUNT_W-1:0] pend_count_next;
    logic               led_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               done_next;

    logic               req;
    logic               timer_clr;
    logic [TIMER_W-1:0] timer_limit;
    logic               timer_expire;

    // A zero-count start is never a request, whatever the state.
    assign req = bus.start && (bus.count != '0);

    // One shared timer; its interval length follows the current state.
    assign timer_limit = (state_reg == ON) ? ON_TICKS : OFF_TICKS;

    interval_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .limit  (timer_limit),
        .expire (timer_expire)
    );

    // Next-state, counters and pending request.
    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        pend_valid_next = pend_valid_reg;
        pend_count_next = pend_count_reg;
        done_next       = 1'b0;
        timer_clr       = 1'b0;

        case (state_reg)
            IDLE: begin
                // Hold the timer at zero so ON starts a full interval.
                timer_clr = 1'b1;
                if (req) begin
                    remaining_next = bus.count;
                    state_next     = ON;
                end
            end

            ON: begin
                if (req) begin
                    pend_valid_next = 1'b1;
                    pend_count_next = bus.count;
                end
                if (timer_expire) begin
                    timer_clr  = 1'b1;
                    state_next = OFF;
                end
            end

            OFF: begin
                if (req) begin
                    pend_valid_next = 1'b1;
                    pend_count_next = bus.count;
                end
                if (timer_expire) begin
                    timer_clr = 1'b1;
                    if (remaining_reg > COUNT_W'(1)) begin
                        remaining_next = remaining_reg - COUNT_W'(1);
                        state_next     = ON;
                    end else begin
                        // Final gap of this sequence: report completion and
                        // chain straight into whatever request is waiting; a
                        // start arriving on this very cycle is the newest one.
                        done_next = 1'b1;
                        if (req) begin
                            remaining_next  = bus.count;
                            pend_valid_next = 1'b0;
                            state_next      = ON;
                        end else if (pend_valid_reg) begin
                            remaining_next  = pend_count_reg;
                            pend_valid_next = 1'b0;
                            state_next      = ON;
                        end else begin
                            remaining_next = '0;
                            state_next     = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_next     = IDLE;
                remaining_next = '0;
            end
        endcase
    end

    // State, counters and pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            pend_valid_reg <= 1'b0;
            pend_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            pend_valid_reg <= pend_valid_next;
            pend_count_reg <= pend_count_next;
        end
    end

    // Outputs are registered copies of the next-state decode so they change
    // on the same edge as the state and carry no combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg  <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            led_reg  <= (state_next == ON);
            busy_reg <= (state_next != IDLE);
            done_reg <= done_next;
        end
    end

    assign bus.led  = led_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_led_blinker.sv
// Randomised + directed bench for led_blinker (1 kHz clock, 3 ms on, 2 ms off).
// The reference model tracks each running sequence as an interval on the
// cycle axis and derives the expected LED/busy/done levels arithmetically.
module tb_led_blinker;
    import blink_pkg::*;

    localparam int ON_T   = 3;
    localparam int OFF_T  = 2;
    localparam int PERIOD = ON_T + OFF_T;

    typedef struct {
        int cyc;
        bit led;
        bit busy;
        bit done;
    } exp_t;

    logic clk;
    logic rst;

    led_blinker_if bus ();

    led_blinker #(
        .clk_freq (1000),
        .on_ms    (3),
        .off_ms   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    // Model: one running sequence spanning accept cycle a .. final-gap cycle e.
    int cyc        = 0;
    bit have_seq   = 0;
    int seq_a      = 0;
    int seq_e      = 0;
    bit pend_v     = 0;
    int pend_c     = 0;

    // Drive one cycle of stimulus and push the expected outputs for the next
    // cycle. Reset in a cycle also zeroes that cycle's expectation, since it
    // acts asynchronously.
    task automatic drive_cycle(input bit r, input bit s, input int c);
        exp_t x;
        bit   is_req;
        bit   done_e;
        @(posedge clk);
        #1;
        rst       = r;
        bus.start = s;
        bus.count = 4'(c);
        cyc++;
        x.cyc  = cyc + 1;
        x.led  = 0;
        x.busy = 0;
        x.done = 0;
        if (r) begin
            have_seq = 0;
            pend_v   = 0;
            if (sb_q.size() > 0) void'(sb_q.pop_back());
            sb_q.push_back('{cyc, 1'b0, 1'b0, 1'b0});
            sb_q.push_back(x);
            return;
        end
        is_req = s && (c != 0);
        done_e = 0;
        if (have_seq && cyc == seq_e) begin
            done_e = 1;
            if (is_req) begin
                seq_a = cyc; seq_e = cyc + PERIOD * c; pend_v = 0;
                $display("txn cycle %0d: start count=%0d launched at sequence end", cyc, c);
            end else if (pend_v) begin
                seq_a = cyc; seq_e = cyc + PERIOD * pend_c; pend_v = 0;
            end else begin
                have_seq = 0;
            end
        end else if (have_seq) begin
            if (is_req) begin
                pend_v = 1; pend_c = c;
                $display("txn cycle %0d: start count=%0d queued", cyc, c);
            end
        end else if (is_req) begin
            have_seq = 1; seq_a = cyc; seq_e = cyc + PERIOD * c;
            $display("txn cycle %0d: start count=%0d accepted", cyc, c);
        end
        x.done = done_e;
        if (done_e) done_exp++;
        if (have_seq) begin
            x.busy = 1;
            x.led  = ((cyc - seq_a) % PERIOD) < ON_T;
        end
        sb_q.push_back(x);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents its levels; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({bus.led, bus.busy, bus.done} !== {e.led, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got led=%b busy=%b done=%b, expected led=%b busy=%b done=%b",
                             e.cyc, bus.led, bus.busy, bus.done, e.led, e.busy, e.done);
                end
                if (bus.done === 1'b1) begin
                    done_seen++;
                    $display("txn cycle %0d: done pulse", e.cyc);
                end
            end
        end
    end

    initial begin
        int c;
        bit s;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.count = 4'd0;

        // Reset state.
        drive_cycle(1, 0, 0);
        drive_cycle(1, 0, 0);
        idle_cycles(3);

        // Single blink.
        drive_cycle(0, 1, 1);
        idle_cycles(8);

        // Three blinks.
        drive_cycle(0, 1, 3);
        idle_cycles(18);

        // Zero count is a no-op, then a queued request with last-wins overwrite.
        drive_cycle(0, 1, 0);
        idle_cycles(4);
        drive_cycle(0, 1, 2);
        idle_cycles(1);
        drive_cycle(0, 1, 1);
        idle_cycles(1);
        drive_cycle(0, 1, 4);
        drive_cycle(0, 1, 0);
        idle_cycles(36);

        // Start on the exact cycle the final gap ends.
        drive_cycle(0, 1, 1);
        idle_cycles(4);
        drive_cycle(0, 1, 1);
        idle_cycles(8);

        // Reset mid-ON, then a normal single blink.
        drive_cycle(0, 1, 5);
        idle_cycles(2);
        drive_cycle(1, 0, 0);
        idle_cycles(2);
        drive_cycle(0, 1, 1);
        idle_cycles(8);

        // Random traffic, biased to hit the final-gap cycle with a start.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive_cycle(1, 0, 0);
            end else begin
                s = ($urandom_range(0, 5) == 0);
                if (have_seq && (cyc + 1 == seq_e) && $urandom_range(0, 1) == 1) s = 1;
                c = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
                if ($urandom_range(0, 19) == 0) c = $urandom_range(1, 15);
                drive_cycle(0, s, c);
            end
        end

        // Drain: finish any sequence still running.
        for (int i = 0; i < 200 && have_seq; i++) drive_cycle(0, 0, 0);
        idle_cycles(4);
        @(negedge clk);
        #1;

        checks++;
        if (done_seen != done_exp) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, expected %0d", done_seen, done_exp);
        end
        checks++;
        if (have_seq) begin
            errors++;
            $display("FAIL drain: model sequence still running at end of run");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 Parameter clk_freq, default 50_000_000, clock frequency in Hz (legal: >= 1000).
REQ-002 Parameter on_ms, default 100, LED on-time per blink in ms (legal: >= 1).
REQ-003 Parameter off_ms, default 100, LED off-time after each blink in ms (legal: >= 1).
REQ-004 Derived constants SHALL be ON_TICKS = clk_freq/1000*on_ms and OFF_TICKS = clk_freq/1000*off_ms, held in a 32-bit counter.
REQ-005 clk  input  1  sole clock, all state on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  single-cycle request strobe.
REQ-008 count  input  4  number of blinks requested with start (1..15; 0 = no-op).
REQ-009 led  output  1  registered LED drive, 1 = lit.
REQ-010 busy  output  1  high while a sequence is running (states ON or OFF).
REQ-011 done  output  1  one-cycle pulse when a sequence's final OFF interval ends.

Function
REQ-012 The FSM SHALL have three states: IDLE, ON, OFF.
REQ-013 In IDLE, start=1 with count!=0 SHALL latch count into remaining, clear the timer and enter ON.
REQ-014 start=1 with count==0 SHALL be ignored in every state, with no state change, no pending capture and no done.
REQ-015 led SHALL be 1 exactly in state ON, first high on the cycle after the accepting start edge.
REQ-016 ON SHALL last exactly ON_TICKS cycles, then the FSM enters OFF with the timer cleared.
REQ-017 OFF SHALL last exactly OFF_TICKS cycles. At its end remaining decrements. If remaining was >1 the FSM re-enters ON. If remaining was 1, done=1 for one cycle.
REQ-018 On the final OFF end, if a request is pending, the FSM SHALL load the pending count and enter ON in the same cycle, with no IDLE cycle and busy staying 1. Otherwise it enters IDLE.
REQ-019 A start with count!=0 while busy=1 SHALL be stored in a one-deep pending register. A later such start overwrites it, last-wins.
REQ-020 A start in the same cycle as the final OFF end SHALL be treated as pending and launched immediately per REQ-018.
REQ-021 Timer SHALL be a 32-bit up-counter compared with (TICKS-1). Wrap-around SHALL be impossible for legal parameters.
REQ-022 remaining SHALL be 4 bits and SHALL never decrement below 1 while in ON or OFF.
REQ-023 busy SHALL be 1 in ON and OFF, and 0 in IDLE.
REQ-024 done SHALL never be asserted for a count==0 request or for an interrupted sequence.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, with led=0, busy=0, done=0, timer=0, remaining=0 and pending cleared.
REQ-026 Reset mid-sequence SHALL abort it without a done pulse. The first start after rst deasserts is accepted normally.

Structure
REQ-027 Package blink_pkg SHALL hold the state enum typedef (IDLE, ON, OFF) and a function computing tick counts from clk_freq and ms.
REQ-028 One sub-module, interval_timer, SHALL provide a clearable 32-bit counter with an expire flag. led_blinker instantiates it once and feeds it ON_TICKS or OFF_TICKS by state.
REQ-029 All outputs SHALL come directly from flip-flops.

Verification (clk_freq=1000, on_ms=3, off_ms=2, so ON_TICKS=3, OFF_TICKS=2)
REQ-030 Single blink: start, count=1 at cycle 0 -> led=1 for cycles 1-3 and led=0 for cycles 4-5. done=1 on cycle 6 and busy=0 from cycle 6.
REQ-031 Three blinks: count=3 -> exactly three led pulses of 3 cycles separated by 2-cycle gaps, with one done pulse after the third gap.
REQ-032 Zero/queue: count=0 -> no activity. Next, count=2, then count=1 at cycle 2 and count=4 at cycle 4 -> after 2 blinks, 4 blinks follow back-to-back with busy never low, and done pulses twice.
REQ-033 Simultaneous: start count=1 in the same cycle as the final OFF end -> new ON starts the next cycle, with done=1 for the first sequence only.
REQ-034 Reset mid-ON with count=5 -> led=0, busy=0 immediately and done never asserted. A start count=1 after release -> normal single blink.
